// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared constants and ack state encoding for the interrupt controller
package interrupt_controller_pkg;

  localparam int          NUM_IRQ     = 5;
  localparam int          IRQ_IDX_W   = $clog2(NUM_IRQ);
  localparam logic [15:0] IF_ADDR     = 16'hFF0F;
  localparam logic [15:0] IE_ADDR     = 16'hFFFF;
  localparam logic [7:0]  VECTOR_BASE = 8'h40;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_HOLD = 1'b1
  } ack_state_e;

endpackage

// File: rtl/interrupt_controller_edge.sv
// rtl/interrupt_controller_edge.sv - enabled rising-edge detector producing one-cycle request pulses
module rising_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             i_Clk,
  input  logic             i_nRst,
  input  logic             i_Enable,
  input  logic [WIDTH-1:0] i_Level,
  output logic [WIDTH-1:0] o_Pulse
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  // Previous level only advances on enabled cycles, so an edge spanning a stall is still seen.
  always_comb begin
    prev_d = prev_q;
    if (i_Enable) prev_d = i_Level;
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) prev_q <= '0;
    else         prev_q <= prev_d;
  end

  assign o_Pulse = i_Level & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - IF/IE registers, request edge latching and CPU interrupt acknowledge
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_nRst,
  input  logic               i_Enable,
  input  logic [15:0]        i_Address,
  input  logic [7:0]         i_Bus,
  input  logic               i_Bus_Out,
  input  logic               i_Bus_In,
  input  logic [NUM_IRQ-1:0] i_Requests,
  input  logic               i_Handle_Interrupt,
  output logic [NUM_IRQ-1:0] o_Interrupts,
  output logic [7:0]         o_Data,
  output logic               o_Data_Valid,
  output logic [7:0]         o_Vector
);

  logic [NUM_IRQ-1:0]   if_q, if_d;
  logic [7:0]           ie_q, ie_d;
  logic [7:0]           vector_q, vector_d;
  ack_state_e           state_q, state_d;
  logic [NUM_IRQ-1:0]   req_pulse;
  logic [NUM_IRQ-1:0]   pending;
  logic [IRQ_IDX_W-1:0] ack_idx;
  logic                 if_hit, ie_hit;

  function automatic logic [IRQ_IDX_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    lowest_set = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IRQ_IDX_W'(i);
    end
  endfunction

  rising_edge_detect #(.WIDTH(NUM_IRQ)) u_req_edge (
    .i_Clk    (i_Clk),
    .i_nRst   (i_nRst),
    .i_Enable (i_Enable),
    .i_Level  (i_Requests),
    .o_Pulse  (req_pulse)
  );

  assign pending = if_q & ie_q[NUM_IRQ-1:0];
  assign ack_idx = lowest_set(pending);

  // Write first, then ack clear, then edge set: a fresh request is never lost.
  always_comb begin
    if_d     = if_q;
    ie_d     = ie_q;
    vector_d = vector_q;
    state_d  = state_q;
    if (i_Enable) begin
      if (i_Bus_Out && i_Address == IF_ADDR) if_d = i_Bus[NUM_IRQ-1:0];
      if (i_Bus_Out && i_Address == IE_ADDR) ie_d = i_Bus;
      case (state_q)
        ACK_IDLE: begin
          if (i_Handle_Interrupt) begin
            state_d = ACK_HOLD;
            if (|pending) begin
              if_d[ack_idx] = 1'b0;
              vector_d      = VECTOR_BASE + 8'({ack_idx, 3'b000});
            end else begin
              vector_d = 8'h00;
            end
          end
        end
        ACK_HOLD: begin
          if (!i_Handle_Interrupt) state_d = ACK_IDLE;
        end
        default: state_d = ACK_IDLE;
      endcase
      if_d = if_d | req_pulse;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      if_q     <= '0;
      ie_q     <= '0;
      vector_q <= '0;
      state_q  <= ACK_IDLE;
    end else begin
      if_q     <= if_d;
      ie_q     <= ie_d;
      vector_q <= vector_d;
      state_q  <= state_d;
    end
  end

  assign if_hit = i_Bus_In && (i_Address == IF_ADDR);
  assign ie_hit = i_Bus_In && (i_Address == IE_ADDR);

  always_comb begin
    o_Data = 8'h00;
    if (if_hit)      o_Data = {{(8 - NUM_IRQ){1'b1}}, if_q};
    else if (ie_hit) o_Data = ie_q;
  end

  assign o_Data_Valid = if_hit | ie_hit;
  assign o_Interrupts = pending;
  assign o_Vector     = vector_q;

endmodule
